// File: rtl/mult_control_if.sv
// Control/strobe bundle between mult_control and the X:A:B datapath.
// master = control unit, slave = datapath side.
interface mult_control_if;
  logic Execute;
  logic ClearA_LoadB;
  logic M;
  logic ld_b;
  logic clr_xa;
  logic add;
  logic sub;
  logic shift;
  logic busy;
  logic done;

  modport master (
    input  Execute, ClearA_LoadB, M,
    output ld_b, clr_xa, add, sub, shift, busy, done
  );

  modport slave (
    output Execute, ClearA_LoadB, M,
    input  ld_b, clr_xa, add, sub, shift, busy, done
  );
endinterface

// File: rtl/mult_control.sv
// Sequencer for the 8-bit signed shift-add multiplier (clear, 8 eval/shift steps, hold).
// Optional MULT_SKIP_ZERO_ADD_EN: EVAL with M=0 shifts directly, skipping the SHIFT state.
module mult_control (
  input  logic           Clk,
  input  logic           Reset,
  mult_control_if.master ctl
);

  typedef enum logic [2:0] {StIdle, StClear, StEval, StShift, StHold} state_e;

  state_e     state_q;
  logic [2:0] k_q;
  logic       first_q;  // marks the first HOLD cycle so done is a single pulse

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      first_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ctl.Execute) begin
            state_q <= StClear;
            k_q     <= 3'd0;
          end
        end
        StClear: state_q <= StEval;
        StEval: begin
`ifdef MULT_SKIP_ZERO_ADD_EN
          if (!ctl.M) begin
            if (k_q == 3'd7) begin
              state_q <= StHold;
              first_q <= 1'b1;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end else begin
            state_q <= StShift;
          end
`else
          state_q <= StShift;
`endif
        end
        StShift: begin
          if (k_q == 3'd7) begin
            state_q <= StHold;
            first_q <= 1'b1;
          end else begin
            k_q     <= k_q + 3'd1;
            state_q <= StEval;
          end
        end
        StHold: begin
          if (!ctl.Execute) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic ld_b, clr_xa, add, sub, shift, busy, done;

  // Strobes are gated by Reset so the datapath is untouched on the reset edge.
  always_comb begin
    ld_b   = 1'b0;
    clr_xa = 1'b0;
    add    = 1'b0;
    sub    = 1'b0;
    shift  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    if (!Reset) begin
      case (state_q)
        StIdle:  ld_b = ctl.ClearA_LoadB & ~ctl.Execute;
        StClear: begin
          clr_xa = 1'b1;
          busy   = 1'b1;
        end
        StEval: begin
          busy = 1'b1;
          if (ctl.M) begin
            if (k_q == 3'd7) sub = 1'b1;
            else             add = 1'b1;
          end
`ifdef MULT_SKIP_ZERO_ADD_EN
          else begin
            shift = 1'b1;
          end
`endif
        end
        StShift: begin
          shift = 1'b1;
          busy  = 1'b1;
        end
        StHold:  done = first_q;
        default: ;
      endcase
    end
  end

  assign ctl.ld_b   = ld_b;
  assign ctl.clr_xa = clr_xa;
  assign ctl.add    = add;
  assign ctl.sub    = sub;
  assign ctl.shift  = shift;
  assign ctl.busy   = busy;
  assign ctl.done   = done;

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control: a behavioural X:A:B datapath closes the loop, products
// and strobe statistics are predicted from plain arithmetic and checked at each done pulse.
module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset;
  logic execute;
  logic clb;
  logic [7:0] s_reg = 8'd0;
  logic [7:0] din = 8'd0;

  always #5 Clk = ~Clk;

  mult_control_if ctl ();

  mult_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .ctl   (ctl)
  );

  assign ctl.Execute      = execute;
  assign ctl.ClearA_LoadB = clb;

  // Datapath model reacting to the strobes
  logic       xr = 1'b0;
  logic [7:0] ar = 8'd0;
  logic [7:0] br = 8'd0;
  assign ctl.M = br[0];

  always @(posedge Clk) begin
    if (ctl.ld_b) begin
      br <= din; xr <= 1'b0; ar <= 8'd0;
    end else if (ctl.clr_xa) begin
      xr <= 1'b0; ar <= 8'd0;
    end else if (ctl.add) begin
      {xr, ar} <= {ar[7], ar} + {s_reg[7], s_reg};
    end else if (ctl.sub) begin
      {xr, ar} <= {ar[7], ar} - {s_reg[7], s_reg};
    end else if (ctl.shift) begin
      ar <= {xr, ar[7:1]};
      br <= {ar[0], br[7:1]};
    end
  end

  typedef struct {
    logic [16:0] xab;
    int          lat;
    int          adds;
    int          subs;
    int          shifts;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int done_total = 0;
  int ld_in_run = 0;
  bit in_run = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  int  cyc = 0;
  int  start_cyc = 0;
  int  nadd, nsub, nsh, nbusy;
  bit  active = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    int   nstrobe;
    cyc++;
    nstrobe = int'(ctl.ld_b) + int'(ctl.clr_xa) + int'(ctl.add) + int'(ctl.sub)
            + int'(ctl.shift);
    check("strobe_onehot", (nstrobe > 1) ? 1 : 0, 0);
    if (in_run && ctl.ld_b) ld_in_run++;
    if (Reset) begin
      active = 1'b0;
    end else begin
      if (ctl.clr_xa) begin
        active = 1'b1; start_cyc = cyc;
        nadd = 0; nsub = 0; nsh = 0; nbusy = 0;
      end
      if (active) begin
        nadd  += int'(ctl.add);
        nsub  += int'(ctl.sub);
        nsh   += int'(ctl.shift);
        nbusy += int'(ctl.busy);
      end
      if (ctl.done) begin
        done_total++;
        if (active) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("product_xab", {xr, ar, br}, e.xab);
            check("latency", cyc - start_cyc, e.lat);
            check("busy_cycles", nbusy, e.lat);
            check("add_count", nadd, e.adds);
            check("sub_count", nsub, e.subs);
            check("shift_count", nsh, e.shifts);
          end
        end
        active = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_quiet(input string name);
    @(negedge Clk);
    check(name, {ctl.ld_b, ctl.clr_xa, ctl.add, ctl.sub, ctl.shift, ctl.busy, ctl.done}, 0);
  endtask

  function automatic exp_t model(input logic [7:0] s, input logic [7:0] b);
    exp_t e;
    int   p;
    p = int'($signed(s)) * int'($signed(b));
    e.xab    = {p[15], p[15:0]};
    e.adds   = $countones(b[6:0]);
    e.subs   = int'(b[7]);
    e.shifts = 8;
`ifdef MULT_SKIP_ZERO_ADD_EN
    e.lat    = 9 + $countones(b);
`else
    e.lat    = 17;
`endif
    return e;
  endfunction

  task automatic run(input logic [7:0] s, input logic [7:0] b, input int hold, input bit noisy);
    int target;
    bit got;
    din = b; clb = 1'b1;
    @(negedge Clk);
    check("ld_b_in_idle", ctl.ld_b, 1);
    tick();
    s_reg = s; execute = 1'b1; clb = noisy;  // Execute must win over a concurrent load
    sbq.push_back(model(s, b));
    target = done_total + 1;
    ld_in_run = 0; in_run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (noisy) clb = 1'($urandom);
      if (done_total >= target) got = 1'b1;
    end
    check("done_seen", got, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (noisy) clb = 1'($urandom);
    end
    check("done_pulses", done_total, target);
    check("ld_b_during_run", ld_in_run, 0);
    in_run = 1'b0; clb = 1'b0; execute = 1'b0;
    tick();
    expect_quiet("idle_after_release");
    tick();
  endtask

  initial begin
    int base_done;
    Reset = 1'b1; execute = 1'b1; clb = 1'b0;
    tick(); tick();
    Reset = 1'b0; execute = 1'b0;
    @(negedge Clk);
    check("reset_beats_execute", {ctl.busy, ctl.clr_xa}, 0);
    for (int i = 0; i < 5; i++) expect_quiet("reset_idle");
    tick();

    run(8'd4, 8'd5, 2, 1'b0);
    run(8'hFD, 8'h80, 1, 1'b1);
    run(8'($urandom), 8'($urandom), 40, 1'b1);  // held Execute: one run only
    run(8'h7F, 8'h00, 0, 1'b0);
    run(8'h80, 8'hFF, 0, 1'b0);
    for (int n = 0; n < 12; n++)
      run(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Reset mid-run with ClearA_LoadB toggling
    din = 8'hB7; clb = 1'b1;
    tick();
    clb = 1'b1; execute = 1'b1; s_reg = 8'h33;
    base_done = done_total;
    ld_in_run = 0; in_run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      clb = 1'($urandom);
    end
    Reset = 1'b1; execute = 1'b0; clb = 1'b0;
    tick();
    Reset = 1'b0;
    in_run = 1'b0;
    @(negedge Clk);
    check("after_reset_outputs",
          {ctl.ld_b, ctl.clr_xa, ctl.add, ctl.sub, ctl.shift, ctl.busy, ctl.done}, 0);
    for (int i = 0; i < 3; i++) expect_quiet("after_reset_quiet");
    check("reset_no_done", done_total, base_done);
    check("reset_ld_b_during_run", ld_in_run, 0);
    tick();

    run(8'h7F, 8'h81, 1, 1'b0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
